// File: rtl/wb_initiator.sv
// Wishbone classic single-access initiator: one bus cycle per command, with an
// ACK timeout, and valid/ready command and response channels.
module wb_initiator #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             busy,
  output logic             wb_CYC,
  output logic             wb_STB,
  output logic             wb_WE,
  output logic [SEL_W-1:0] wb_SEL,
  output logic [ADR_W-1:0] wb_ADR,
  output logic [DAT_W-1:0] wb_DAT_MOSI,
  input  logic [DAT_W-1:0] wb_DAT_MISO,
  input  logic             wb_ACK
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   mosi_q, mosi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    mosi_d      = mosi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          mosi_d  = cmd_dat;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ACK wins over a timeout landing on the same edge.
        if (wb_ACK) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_DAT_MISO;
          state_d     = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          stb_d       = 1'b0;
          cnt_d       = cnt_inc;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      mosi_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wb_CYC      = stb_q;
  assign wb_STB      = stb_q;
  assign wb_WE       = we_q;
  assign wb_SEL      = sel_q;
  assign wb_ADR      = adr_q;
  assign wb_DAT_MOSI = mosi_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_dat     = rsp_dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: the target side is driven by hand from each
// scenario task, with expected values written out as constants.
module tb_wb_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [0:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;
  logic        wb_CYC;
  logic        wb_STB;
  logic        wb_WE;
  logic [0:0]  wb_SEL;
  logic [31:0] wb_ADR;
  logic [31:0] wb_DAT_MOSI;
  logic [31:0] wb_DAT_MISO;
  logic        wb_ACK;

  int npass;
  int ntotal;

  wb_initiator #(.ADR_W(32), .DAT_W(32), .SEL_W(1), .TIMEOUT(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_dat     (cmd_dat),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dat     (rsp_dat),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .wb_CYC      (wb_CYC),
    .wb_STB      (wb_STB),
    .wb_WE       (wb_WE),
    .wb_SEL      (wb_SEL),
    .wb_ADR      (wb_ADR),
    .wb_DAT_MOSI (wb_DAT_MOSI),
    .wb_DAT_MISO (wb_DAT_MISO),
    .wb_ACK      (wb_ACK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    ntotal++;
    if ({wb_CYC, wb_STB, wb_WE, wb_SEL, wb_ADR, wb_DAT_MOSI} !== 68'd0) begin
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%b adr=%h mosi=%h expected all 0",
               wb_CYC, wb_STB, wb_WE, wb_SEL, wb_ADR, wb_DAT_MOSI);
    end else npass++;
    ntotal++;
    if ({rsp_valid, rsp_err, rsp_dat, busy} !== 35'd0) begin
      $display("FAIL reset_rsp: got valid=%b err=%b dat=%h busy=%b expected all 0",
               rsp_valid, rsp_err, rsp_dat, busy);
    end else npass++;
    rst_n = 1'b1;
    tick();
    ntotal++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    else npass++;
  endtask

  task automatic test_write();
    int n;
    wb_DAT_MISO = 32'hFFFF_FFFF;
    ntotal++;
    if (cmd_ready !== 1'b1) $display("FAIL wr_ready_before: got %b expected 1", cmd_ready);
    else npass++;
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
    n = 0;
    if (wb_STB) n++;
    ntotal++;
    if ({wb_CYC, wb_WE, wb_SEL, wb_ADR, wb_DAT_MOSI, cmd_ready, busy} !==
        {1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
      $display("FAIL wr_bus_first: got cyc=%b we=%b sel=%b adr=%h mosi=%h rdy=%b busy=%b expected 1 1 1 30000004 deadbeef 0 1",
               wb_CYC, wb_WE, wb_SEL, wb_ADR, wb_DAT_MOSI, cmd_ready, busy);
    end else npass++;
    tick();
    if (wb_STB) n++;
    tick();
    if (wb_STB) n++;
    ntotal++;
    if ({wb_CYC, wb_WE, wb_ADR, wb_DAT_MOSI} !== {1'b1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF}) begin
      $display("FAIL wr_bus_stable: got cyc=%b we=%b adr=%h mosi=%h expected 1 1 30000004 deadbeef",
               wb_CYC, wb_WE, wb_ADR, wb_DAT_MOSI);
    end else npass++;
    wb_ACK = 1'b1;
    tick();
    wb_ACK = 1'b0;
    if (wb_STB) n++;
    ntotal++;
    if (n !== 3 || wb_CYC !== 1'b0) $display("FAIL wr_stb_cycles: got %0d cyc=%b expected 3 cyc=0", n, wb_CYC);
    else npass++;
    ntotal++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL wr_rsp: got valid=%b err=%b dat=%h expected 1 0 00000000", rsp_valid, rsp_err, rsp_dat);
    end else npass++;
    ntotal++;
    if ({wb_ADR, wb_WE} !== {32'h3000_0004, 1'b1}) begin
      $display("FAIL wr_addr_hold: got adr=%h we=%b expected 30000004 1", wb_ADR, wb_WE);
    end else npass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ntotal++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL wr_handshake: got valid=%b busy=%b rdy=%b expected 0 0 1", rsp_valid, busy, cmd_ready);
    end else npass++;
  endtask

  task automatic test_read();
    int n;
    issue(1'b0, 32'h3000_0008, 32'hAAAA_5555);
    n = 0;
    if (wb_STB) n++;
    wb_ACK = 1'b1;
    wb_DAT_MISO = 32'h1234_5678;
    tick();
    wb_ACK = 1'b0;
    wb_DAT_MISO = 32'h0;
    if (wb_STB) n++;
    ntotal++;
    if (n !== 1) $display("FAIL rd_stb_cycles: got %0d expected 1", n);
    else npass++;
    ntotal++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      $display("FAIL rd_rsp: got valid=%b err=%b dat=%h expected 1 0 12345678", rsp_valid, rsp_err, rsp_dat);
    end else npass++;
    ntotal++;
    if ({wb_WE, wb_ADR, wb_DAT_MOSI} !== {1'b0, 32'h3000_0008, 32'hAAAA_5555}) begin
      $display("FAIL rd_bus_fields: got we=%b adr=%h mosi=%h expected 0 30000008 aaaa5555",
               wb_WE, wb_ADR, wb_DAT_MOSI);
    end else npass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    wb_DAT_MISO = 32'h5A5A_5A5A;
    issue(1'b0, 32'h3000_0010, 32'h0);
    n = 0;
    while (wb_STB && n < 20) begin
      n++;
      tick();
    end
    ntotal++;
    if (n !== 4) $display("FAIL to_stb_cycles: got %0d expected 4", n);
    else npass++;
    ntotal++;
    if ({wb_CYC, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      $display("FAIL to_rsp: got cyc=%b valid=%b err=%b dat=%h expected 0 1 1 00000000",
               wb_CYC, rsp_valid, rsp_err, rsp_dat);
    end else npass++;
    tick();
    wb_ACK = 1'b1;
    tick();
    wb_ACK = 1'b0;
    ntotal++;
    if ({wb_CYC, rsp_valid, rsp_err, rsp_dat, busy} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b1}) begin
      $display("FAIL to_late_ack: got cyc=%b valid=%b err=%b dat=%h busy=%b expected 0 1 1 00000000 1",
               wb_CYC, rsp_valid, rsp_err, rsp_dat, busy);
    end else npass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wb_ACK = 1'b1;
    tick();
    tick();
    wb_ACK = 1'b0;
    ntotal++;
    if ({wb_CYC, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
      $display("FAIL idle_ack_ignored: got cyc=%b valid=%b busy=%b rdy=%b expected 0 0 0 1",
               wb_CYC, rsp_valid, busy, cmd_ready);
    end else npass++;
  endtask

  task automatic test_backpressure();
    issue(1'b0, 32'h3000_0020, 32'h0);
    wb_ACK = 1'b1;
    wb_DAT_MISO = 32'hCAFE_F00D;
    tick();
    wb_ACK = 1'b0;
    wb_DAT_MISO = 32'h0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0024;
    cmd_dat   = 32'h0BAD_CAFE;
    for (int i = 0; i < 10; i++) begin
      ntotal++;
      if ({rsp_valid, rsp_dat, cmd_ready, busy, wb_STB} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0}) begin
        $display("FAIL bp_hold[%0d]: got valid=%b dat=%h rdy=%b busy=%b stb=%b expected 1 cafef00d 0 1 0",
                 i, rsp_valid, rsp_dat, cmd_ready, busy, wb_STB);
      end else npass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ntotal++;
    if ({rsp_valid, wb_STB, cmd_ready} !== 3'b001) begin
      $display("FAIL bp_no_same_edge: got valid=%b stb=%b rdy=%b expected 0 0 1", rsp_valid, wb_STB, cmd_ready);
    end else npass++;
    tick();
    cmd_valid = 1'b0;
    ntotal++;
    if ({wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI} !== {1'b1, 1'b1, 32'h3000_0024, 32'h0BAD_CAFE}) begin
      $display("FAIL bp_next_cmd: got stb=%b we=%b adr=%h mosi=%h expected 1 1 30000024 0badcafe",
               wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI);
    end else npass++;
    wb_ACK = 1'b1;
    tick();
    wb_ACK = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b1, 32'h3000_0030, 32'h7777_7777);
    tick();
    ntotal++;
    if (wb_STB !== 1'b1) $display("FAIL rst_mid_pre: got stb=%b expected 1", wb_STB);
    else npass++;
    rst_n = 1'b0;
    wb_ACK = 1'b1;
    tick();
    wb_ACK = 1'b0;
    ntotal++;
    if ({wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, rsp_valid, busy} !== 69'd0) begin
      $display("FAIL rst_mid_outputs: got cyc=%b stb=%b we=%b adr=%h mosi=%h valid=%b busy=%b expected all 0",
               wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, rsp_valid, busy);
    end else npass++;
    rst_n = 1'b1;
    tick();
    tick();
    ntotal++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      $display("FAIL rst_mid_no_rsp: got valid=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
    end else npass++;
    issue(1'b0, 32'h3000_0034, 32'h0);
    wb_ACK = 1'b1;
    wb_DAT_MISO = 32'h0000_BEEF;
    tick();
    wb_ACK = 1'b0;
    ntotal++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0000_BEEF}) begin
      $display("FAIL rst_mid_recover: got valid=%b err=%b dat=%h expected 1 0 0000beef", rsp_valid, rsp_err, rsp_dat);
    end else npass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] mem;
    logic [31:0] exp;
    int nrsp;
    mem  = 32'h0;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      issue(i % 2 == 0, 32'h3000_0040, 32'h1111_0000 + 32'(i));
      if (wb_WE) mem = wb_DAT_MOSI;
      wb_DAT_MISO = mem;
      wb_ACK = 1'b1;
      tick();
      wb_ACK = 1'b0;
      if (rsp_valid) nrsp++;
      exp = (i % 2 == 0) ? 32'h0 : 32'h1111_0000 + 32'(i - 1);
      ntotal++;
      if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, exp}) begin
        $display("FAIL b2b[%0d]: got valid=%b err=%b dat=%h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_dat, exp);
      end else npass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    ntotal++;
    if (nrsp !== 8) $display("FAIL b2b_count: got %0d expected 8", nrsp);
    else npass++;
  endtask

  initial begin
    npass       = 0;
    ntotal      = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_adr     = 32'h0;
    cmd_dat     = 32'h0;
    cmd_sel     = 1'b0;
    rsp_ready   = 1'b0;
    wb_DAT_MISO = 32'h0;
    wb_ACK      = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic single-access initiator (bus master) that drives the DSP48 Wishbone target port (wb_CYC/wb_STB/wb_WE/wb_SEL/wb_ADR/wb_DAT_MOSI in, wb_DAT_MISO/wb_ACK out).
- Accepts read/write commands on a valid/ready command channel and runs one bus cycle per command.
- Returns read data or write completion on a valid/ready response channel.
- Includes an ACK timeout so a hung target cannot lock the initiator.
- Used for on-chip self-test and for LA/IO-driven register access to the DSP block.

Parameters:
- ADR_W, 32, address width
- DAT_W, 32, data width
- SEL_W, 1, byte-select width (matches the DSP48 target)
- TIMEOUT, 255, max cycles with STB high and no ACK before abort; legal range 1..65535

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_ni  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADR_W  target address
- cmd_dat  in  DAT_W  write data
- cmd_sel  in  SEL_W  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_dat  out  DAT_W  read data (0 for writes and timeouts)
- rsp_err  out  1  1=timeout abort
- busy  out  1  high in any state other than IDLE
- wb_CYC  out  1  bus cycle
- wb_STB  out  1  strobe
- wb_WE  out  1  write enable
- wb_SEL  out  SEL_W  byte selects
- wb_ADR  out  ADR_W  address
- wb_DAT_MOSI  out  DAT_W  write data to target
- wb_DAT_MISO  in  DAT_W  read data from target
- wb_ACK  in  1  target acknowledge

Behaviour:
- Reset (wb_rst_ni=0 at a rising edge): state=IDLE.
  - All outputs 0 except cmd_ready=1 after the first post-reset edge.
  - wb_CYC, wb_STB, wb_WE, wb_SEL, wb_ADR, wb_DAT_MOSI = 0.
  - rsp_valid, rsp_err, rsp_dat = 0; busy=0; timeout counter = 0.
- The FSM is registered and has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N, register we/adr/dat/sel onto the wb_* outputs, set wb_CYC=wb_STB=1 and clear the counter.
  - Bus signals become visible in the cycle after edge N; state goes to BUS.
- BUS:
  - cmd_ready=0; wb_CYC, wb_STB and all wb_* outputs are held stable.
  - Counter increments each cycle with ACK low.
  - wb_ACK=1 sampled at edge M: drop wb_CYC/wb_STB at M. Latch rsp_dat=wb_DAT_MISO for reads, 0 for writes. Set rsp_err=0, rsp_valid=1, state=RESP. Minimum one cycle of STB high, so single-cycle ACK is supported.
  - Counter reaches TIMEOUT with ACK still low: drop wb_CYC/wb_STB. Set rsp_err=1, rsp_dat=0, rsp_valid=1, state=RESP.
  - ACK takes priority if it coincides with the timeout edge.
- RESP:
  - rsp_valid=1 and response fields held stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid=0, rsp_err=0, state=IDLE.
  - No new command is accepted in the same edge; back-to-back throughput is one access per ≥3 cycles.
- Address/data hold:
  - wb_ADR, wb_WE, wb_SEL, wb_DAT_MOSI keep their last values after the cycle ends; the target ignores them while CYC=0.
  - wb_DAT_MOSI carries cmd_dat for reads too.
- Boundary conditions:
  - wb_ACK high in IDLE or RESP: ignored, no state change.
  - ACK arriving after a timeout abort is also ignored.
  - cmd fields change while not accepted: no effect.
  - Reset asserted mid-BUS: wb_CYC/wb_STB low at that edge; any pending response is discarded.
- Counter width: clog2(TIMEOUT+1) bits; no wrap is possible because it saturates at TIMEOUT.

Test Plan:
- Write: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=1, target ACKs 2 cycles after STB -> CYC/STB high exactly 3 cycles with adr/dat/WE stable; then rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read: cmd we=0 adr=0x3000_0008, target returns 0x1234_5678 with same-cycle ACK -> STB high 1 cycle; rsp_dat=0x1234_5678, rsp_err=0.
- Timeout with TIMEOUT=4: target never ACKs -> CYC drops after 4 cycles; rsp_err=1, rsp_dat=0. An ACK injected 2 cycles later produces no second response.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read -> rsp_valid/rsp_dat stable, cmd_ready=0, busy=1 throughout; a new cmd_valid is not accepted until the cycle after the response handshake.
- Reset mid-BUS: drop wb_rst_ni while STB is high -> all outputs 0 after that edge, no rsp_valid. The next command completes normally.
- Back-to-back: 8 alternating write/read commands to the same address with a 1-cycle-ACK target -> each read returns the preceding write's data; no command is lost or duplicated.
